cell_cfg_loader: RTL

- Serial configuration loader; sits directly upstream of the mux-based logic cell array and drives the 4-bit D truth-table input of every C2/S1/S2 cell.
- Accepts a bitstream over a valid/ready handshake and assembles it in a shadow register.
- Commits the whole frame atomically, so cells never see a partially loaded configuration.

---
 rtl/cell_cfg_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cell_cfg_loader.sv
// Serial configuration loader for the mux-based cell array: shifts a frame into a shadow
// register and commits it atomically to cfg_d. Optional even-parity check: CELL_CFG_PARITY_EN.
module cell_cfg_loader #(
    parameter int unsigned NUM_CELLS = 8,
    parameter int unsigned CFG_W     = 4
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic [NUM_CELLS*CFG_W-1:0] cfg_d,
    output logic                       cfg_done,
    output logic                       cfg_err,
    output logic                       busy
);

    localparam int unsigned TOTAL = NUM_CELLS * CFG_W;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

`ifdef CELL_CFG_PARITY_EN
    typedef enum logic [1:0] {StIdle, StLoad, StPar, StCommit} state_t;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [TOTAL-1:0] cfg_q, cfg_nxt;
    logic             done_q, done_d;
`ifdef CELL_CFG_PARITY_EN
    logic             err_q, err_d;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= StIdle;
            count_q  <= '0;
            shadow_q <= '0;
            cfg_q    <= '0;
            done_q   <= 1'b0;
`ifdef CELL_CFG_PARITY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_nxt;
            done_q   <= done_d;
`ifdef CELL_CFG_PARITY_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        cfg_nxt   = cfg_q;
        done_d    = 1'b0;
        bit_ready = 1'b0;
        busy      = 1'b1;
`ifdef CELL_CFG_PARITY_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = StLoad;
                    count_d  = '0;
                    shadow_d = '0;
`ifdef CELL_CFG_PARITY_EN
                    err_d    = 1'b0;
`endif
                end
            end
            StLoad: begin
                bit_ready = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_valid) begin
                    // Compare-per-bit write keeps the index width independent of TOTAL.
                    for (int unsigned i = 0; i < TOTAL; i++) begin
                        if (count_q == CNT_W'(i)) shadow_d[i] = bit_in;
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(TOTAL - 1)) begin
`ifdef CELL_CFG_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StCommit;
`endif
                    end
                end
            end
`ifdef CELL_CFG_PARITY_EN
            StPar: begin
                bit_ready = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_valid) begin
                    if ((^shadow_q) ^ bit_in) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
`endif
            StCommit: begin
                cfg_nxt = shadow_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cfg_d    = cfg_q;
    assign cfg_done = done_q;
`ifdef CELL_CFG_PARITY_EN
    assign cfg_err  = err_q;
`else
    assign cfg_err  = 1'b0;
`endif

endmodule
